// File: rtl/funprof_dump.sv
// funprof_dump: reader side of the function-profiler counter bank.
// A single-cycle dump_req snapshots all NUM_CNT counters into a shadow file
// in one clock edge, then drains the snapshot one word per beat over a
// valid/ready stream (m_idx 0 .. NUM_CNT-1, m_last on the final word).
// The live counters keep running during the drain; the dump stays coherent
// to the snapshot cycle.
// Optional feature, macro FUNPROF_DUMP_CLEAR_EN: when defined, cnt_clr
// pulses for one cycle after the snapshot edge (read-and-clear profiling).
// When undefined, cnt_clr is tied 0.
module funprof_dump #(
  parameter int unsigned NUM_CNT = 8,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned IDX_W   = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
  input  logic                     dump_req,
  output logic [CNT_W-1:0]         m_data,
  output logic [IDX_W-1:0]         m_idx,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy,
  output logic                     dump_done,
  output logic                     cnt_clr
);

  localparam int unsigned       VEC_W    = NUM_CNT * CNT_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [VEC_W-1:0]   shadow;
  logic [IDX_W-1:0]   nxt_idx;
  logic [CNT_W-1:0]   nxt_data;
  logic               hs;

  // A beat transfers only while valid is up; ready alone means nothing.
  assign hs = m_valid & m_ready;

  // Next word to present: shadow entry at m_idx+1 (only used when not last).
  always_comb begin
    nxt_idx  = m_idx + IDX_W'(1);
    nxt_data = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (nxt_idx == IDX_W'(k)) begin
        nxt_data = shadow[k*CNT_W +: CNT_W];
      end
    end
  end

  // Snapshot / drain FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      m_data    <= '0;
      m_idx     <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_req) begin
            shadow  <= cnt_in;
            m_data  <= cnt_in[CNT_W-1:0];
            m_idx   <= '0;
            m_valid <= 1'b1;
            m_last  <= (LAST_IDX == '0);
            busy    <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          // Outputs hold while stalled; they only move on a handshake.
          if (hs) begin
            if (m_idx == LAST_IDX) begin
              m_valid   <= 1'b0;
              m_last    <= 1'b0;
              busy      <= 1'b0;
              dump_done <= 1'b1;
              state     <= DONE;
            end else begin
              m_idx  <= nxt_idx;
              m_data <= nxt_data;
              m_last <= (nxt_idx == LAST_IDX);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FUNPROF_DUMP_CLEAR_EN
  // Clear the live bank in the cycle after the snapshot edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_clr <= 1'b0;
    end else begin
      cnt_clr <= (state == IDLE) && dump_req;
    end
  end
`else
  assign cnt_clr = 1'b0;
`endif

endmodule

// File: tb/tb_funprof_dump.sv
// Scoreboard bench for funprof_dump (NUM_CNT=4): stimulus pushes expected
// beats, a negedge monitor pops and compares on every handshake.
module tb_funprof_dump;

  localparam int unsigned NUM_CNT = 4;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned IDX_W   = 6;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] data;
    logic             last;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CNT*CNT_W-1:0] cnt_in;
  logic                     dump_req;
  logic [CNT_W-1:0]         m_data;
  logic [IDX_W-1:0]         m_idx;
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_last;
  logic                     busy;
  logic                     dump_done;
  logic                     cnt_clr;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int beats = 0;
  int dones = 0;
  int busy_falls = 0;

  funprof_dump #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .dump_req(dump_req),
    .m_data(m_data), .m_idx(m_idx), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .dump_done(dump_done), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [CNT_W-1:0] d0, input logic [CNT_W-1:0] d1,
                       input logic [CNT_W-1:0] d2, input logic [CNT_W-1:0] d3);
    exp_q.push_back('{idx: 6'd0, data: d0, last: 1'b0});
    exp_q.push_back('{idx: 6'd1, data: d1, last: 1'b0});
    exp_q.push_back('{idx: 6'd2, data: d2, last: 1'b0});
    exp_q.push_back('{idx: 6'd3, data: d3, last: 1'b1});
  endtask

  // Bounded wait for the dump to finish, then confirm exactly one completion.
  task automatic wait_done(input int base_dones, input string name);
    int n = 0;
    while (dones == base_dones && n < 60) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk({name, "_done_count"}, 64'(dones - base_dones), 64'd1);
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: handshake scoreboard, stall stability, done/busy/clear checks.
  logic             prev_stall = 1'b0;
  logic             prev_valid = 1'b0;
  logic             prev_busy  = 1'b0;
  logic             exp_done   = 1'b0;
  logic [CNT_W-1:0] prev_data  = '0;
  logic [IDX_W-1:0] prev_idx   = '0;

  always @(negedge clk) begin
    beat_t e;
    if (reset === 1'b1) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      prev_busy  = 1'b0;
      exp_done   = 1'b0;
    end else begin
      chk("dump_done", 64'(dump_done), 64'(exp_done));
      if (dump_done) dones++;
      exp_done = 1'b0;
      if (m_valid) chk("busy_with_valid", 64'(busy), 64'd1);
      if (prev_busy && !busy) busy_falls++;
`ifdef FUNPROF_DUMP_CLEAR_EN
      chk("cnt_clr", 64'(cnt_clr), 64'(m_valid && !prev_valid));
`else
      chk("cnt_clr", 64'(cnt_clr), 64'd0);
`endif
      if (prev_stall) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", 64'(m_data), 64'(prev_data));
        chk("stall_idx", 64'(m_idx), 64'(prev_idx));
      end
      if (m_valid && m_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got idx %0d data %0h expected no beat", m_idx, m_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_idx", 64'(m_idx), 64'(e.idx));
          chk("beat_data", 64'(m_data), 64'(e.data));
          chk("beat_last", 64'(m_last), 64'(e.last));
          if (e.last) exp_done = 1'b1;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_idx   = m_idx;
      prev_valid = m_valid;
      prev_busy  = busy;
    end
  end

  initial begin
    int b0, d0, f0;
    reset    = 1'b1;
    dump_req = 1'b0;
    m_ready  = 1'b0;
    cnt_in   = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_idx", 64'(m_idx), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(dump_done), 64'd0);
    chk("rst_clr", 64'(cnt_clr), 64'd0);
    tick();

    // Basic dump with ready held high: 4 consecutive beats.
    cnt_in = {32'd40, 32'd30, 32'd20, 32'd10};
    push4(32'd10, 32'd20, 32'd30, 32'd40);
    b0 = beats; d0 = dones;
    m_ready  = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("t1_first_valid", 64'(m_valid), 64'd1);
    chk("t1_first_idx", 64'(m_idx), 64'd0);
    chk("t1_first_busy", 64'(busy), 64'd1);
    repeat (4) tick();
    chk("t1_beats_consecutive", 64'(beats - b0), 64'd4);
    chk("t1_done_pulse", 64'(dump_done), 64'd1);
    chk("t1_busy_low", 64'(busy), 64'd0);
    chk("t1_valid_low", 64'(m_valid), 64'd0);
    tick();
    chk("t1_done_single", 64'(dump_done), 64'd0);
    wait_done(d0, "t1");

    // Live counters change every cycle during the drain.
    cnt_in = {32'd40, 32'd30, 32'd20, 32'd10};
    push4(32'd10, 32'd20, 32'd30, 32'd40);
    d0 = dones;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cnt_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    wait_done(d0, "t2");

    // Consumer stall at idx 1 for 5 cycles.
    cnt_in = {32'hFFFF_FFFF, 32'h8000_0001, 32'd20, 32'd10};
    push4(32'd10, 32'd20, 32'h8000_0001, 32'hFFFF_FFFF);
    d0 = dones;
    m_ready  = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_stall_valid", 64'(m_valid), 64'd1);
      chk("t3_stall_idx", 64'(m_idx), 64'd1);
      chk("t3_stall_data", 64'(m_data), 64'd20);
    end
    m_ready = 1'b1;
    wait_done(d0, "t3");

    // Requests during the drain and on the final handshake are dropped.
    cnt_in = {32'd4, 32'd3, 32'd2, 32'd1};
    push4(32'd1, 32'd2, 32'd3, 32'd4);
    b0 = beats; d0 = dones; f0 = busy_falls;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    tick();
    tick();
    dump_req = 1'b1;
    cnt_in   = {32'd99, 32'd98, 32'd97, 32'd96};
    tick();
    chk("t4_last_flag", 64'(m_last), 64'd1);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_idle_valid", 64'(m_valid), 64'd0);
    end
    chk("t4_beats", 64'(beats - b0), 64'd4);
    chk("t4_dones", 64'(dones - d0), 64'd1);
    chk("t4_busy_falls", 64'(busy_falls - f0), 64'd1);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset at idx 1 aborts the drain, then a fresh full dump follows.
    cnt_in = {32'd40, 32'd30, 32'd20, 32'd10};
    push4(32'd10, 32'd20, 32'd30, 32'd40);
    d0 = dones;
    m_ready  = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    tick();
    chk("t5_at_idx1", 64'(m_idx), 64'd1);
    m_ready = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("t5_rst_valid", 64'(m_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_data", 64'(m_data), 64'd0);
    repeat (3) tick();
    chk("t5_no_done", 64'(dones - d0), 64'd0);
    cnt_in = {32'hCAFE_F00D, 32'h0000_0000, 32'hDEAD_BEEF, 32'h1234_5678};
    push4(32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0000, 32'hCAFE_F00D);
    d0 = dones;
    m_ready  = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("t5_restart_idx", 64'(m_idx), 64'd0);
    wait_done(d0, "t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/funprof_dump.md
Name: funprof_dump

Overview:
- Reader side of the function-profiler counter bank.
- On request, atomically snapshots NUM_CNT free-running cycle counters into a shadow register file.
- Drains the snapshot one word per beat over a valid/ready stream to the host-side collector (bus slave or FIFO).
- Counters keep running during the drain; the dumped values are coherent to the single snapshot cycle.

Parameters:
- NUM_CNT, 8, number of counters in the bank (1..64)
- CNT_W, 32, width of each counter in bits
- IDX_W, 6, width of the index field (must satisfy 2**IDX_W >= NUM_CNT)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cnt_in  in  NUM_CNT*CNT_W  flattened counter values; counter k occupies bits [k*CNT_W +: CNT_W]
- dump_req  in  1  single-cycle request to snapshot and drain
- m_data  out  CNT_W  snapshot value of current counter
- m_idx  out  IDX_W  index of the counter carried in m_data
- m_valid  out  1  beat valid
- m_ready  in  1  consumer ready
- m_last  out  1  asserted with the beat of index NUM_CNT-1
- busy  out  1  high from capture until the last beat is accepted
- dump_done  out  1  single-cycle pulse the cycle after the last handshake
- cnt_clr  out  1  counter-bank clear pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset values: m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0, dump_done=0, cnt_clr=0, state=IDLE, shadow registers=0.
- States and transitions:
  - IDLE: on dump_req=1, latch all of cnt_in into the shadow file on that clock edge and go to SEND. m_idx=0, m_valid=1, busy=1 in the next cycle. Snapshot-to-first-valid latency is 1 cycle.
  - SEND: m_data = shadow[m_idx], registered and stable while m_valid && !m_ready (AXI-stream rules: no data change or valid drop before handshake).
    - On a handshake (m_valid && m_ready) with m_idx < NUM_CNT-1: increment m_idx and present the next word in the following cycle. Back-to-back beats are allowed, 1 beat/cycle max.
    - On a handshake with m_idx = NUM_CNT-1 (m_last=1): go to DONE and drop m_valid.
  - DONE: for one cycle, dump_done=1, busy=0; next state IDLE.
- dump_req while busy (SEND/DONE): ignored, not queued; the shadow file is not overwritten mid-drain.
- dump_req in the same cycle as the final handshake: ignored. A new dump is accepted only in IDLE.
- NUM_CNT=1: the first beat has m_last=1; then DONE.
- Counter values are passed unmodified, full CNT_W; no arithmetic on data. m_idx never exceeds NUM_CNT-1 and never wraps.
- Reset mid-drain: returns to IDLE immediately, m_valid drops the same edge, no dump_done, shadow cleared.
- m_ready is ignored when m_valid=0.

Optional Feature:
- Macro: FUNPROF_DUMP_CLEAR_EN
- Defined: cnt_clr pulses high for exactly 1 cycle, in the cycle after the snapshot edge (coincident with the first m_valid). This gives read-and-clear profiling; the counter bank's reset is ORed with cnt_clr externally. The snapshot is unaffected.
- Undefined: cnt_clr tied 0; counters accumulate across dumps.

Test Plan:
- NUM_CNT=4, cnt_in = {40,30,20,10} (idx3..0), pulse dump_req, m_ready=1 -> beats (idx,data) = (0,10),(1,20),(2,30),(3,40) on 4 consecutive cycles starting 1 cycle after req; m_last only on idx 3; dump_done 1 cycle after the idx-3 handshake.
- Same as above, but change cnt_in every cycle after the snapshot -> dumped values still 10,20,30,40.
- m_ready held 0 for 5 cycles at idx 1 -> m_valid stays 1, m_data=20 and m_idx=1 stable; resumes on m_ready=1.
- dump_req pulsed at idx 2 and in the final-handshake cycle -> no second dump; busy falls once; exactly 4 beats.
- Assert reset during idx 1 -> next cycle m_valid=0, busy=0, no dump_done; a new dump_req yields a full 4-beat dump from idx 0.
- With FUNPROF_DUMP_CLEAR_EN: cnt_clr=1 for exactly one cycle, coincident with first m_valid; without the macro, cnt_clr=0 throughout.
